// File: rtl/m0_multiplier.sv
// m0_multiplier: MULS datapath, low-half product with N/Z flags.
// FAST=1 gives a registered single-cycle multiply; FAST=0 retires RADIX_BITS multiplier bits per cycle.
module m0_multiplier #(
    parameter int WIDTH      = 32,
    parameter int FAST       = 0,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z
);
    logic go;
    assign go = start && !abort;
    if (FAST != 0) begin : g_fast
        logic [WIDTH-1:0] prod;
        assign prod = op_a * op_b;
        assign busy = 1'b0;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                done   <= 1'b0;
                result <= '0;
                flag_n <= 1'b0;
                flag_z <= 1'b0;
            end else begin
                done <= go;
                if (go) begin
                    result <= prod;
                    flag_n <= prod[WIDTH-1];
                    flag_z <= ~|prod;
                end
            end
        end
    end else begin : g_iter
        localparam int N  = WIDTH / RADIX_BITS;
        localparam int CW = $clog2(N);
        typedef enum logic {IDLE, RUN} state_t;
        state_t           state, state_d;
        logic [WIDTH-1:0] a, b, acc, a_d, b_d, acc_d, step;
        logic [CW-1:0]    count, count_d;
        logic             done_d;
        // One radix digit of the shadowed multiplier against the pre-shifted multiplicand
        assign step = acc + a * WIDTH'(b[RADIX_BITS-1:0]);
        assign busy = state == RUN;
        always_comb begin
            state_d = state;
            a_d     = a;
            b_d     = b;
            acc_d   = acc;
            count_d = count;
            done_d  = 1'b0;
            if (state == IDLE) begin
                if (go) begin
                    a_d     = op_a << RADIX_BITS;
                    b_d     = op_b >> RADIX_BITS;
                    acc_d   = op_a * WIDTH'(op_b[RADIX_BITS-1:0]);
                    count_d = CW'(N - 1);
                    state_d = RUN;
                end
            end else if (abort) begin
                state_d = IDLE;
            end else begin
                a_d     = a << RADIX_BITS;
                b_d     = b >> RADIX_BITS;
                acc_d   = step;
                count_d = count - CW'(1);
                done_d  = count == CW'(1);
                state_d = count == CW'(1) ? IDLE : RUN;
            end
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                a      <= '0;
                b      <= '0;
                acc    <= '0;
                count  <= '0;
                done   <= 1'b0;
                result <= '0;
                flag_n <= 1'b0;
                flag_z <= 1'b0;
            end else begin
                state <= state_d;
                a     <= a_d;
                b     <= b_d;
                acc   <= acc_d;
                count <= count_d;
                done  <= done_d;
                if (done_d) begin
                    result <= step;
                    flag_n <= step[WIDTH-1];
                    flag_z <= ~|step;
                end
            end
        end
    end
endmodule

// File: tb/tb_m0_multiplier.sv
// tb_m0_multiplier: directed checks of the fast and all iterative radix configurations side by side.
module tb_m0_multiplier;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  busy, done, fn, fz;
    logic [31:0] res [5];
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat_exp [5] = '{1, 32, 16, 8, 4};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        m0_multiplier #(
            .WIDTH(32),
            .FAST(g == 0 ? 1 : 0),
            .RADIX_BITS(g == 0 ? 1 : 1 << (g - 1))
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .start(start),
            .abort(abort),
            .op_a(op_a),
            .op_b(op_b),
            .busy(busy[g]),
            .done(done[g]),
            .result(res[g]),
            .flag_n(fn[g]),
            .flag_z(fz[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        int          lat [5];
        int          nd [5];
        logic [31:0] got [5];
        logic        gn [5];
        logic        gz [5];
        for (int i = 0; i < 5; i++) begin
            lat[i] = 0;
            nd[i]  = 0;
            got[i] = 'x;
            gn[i]  = 1'bx;
            gz[i]  = 1'bx;
        end
        op_a  = x;
        op_b  = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        for (int c = 1; c <= 40; c++) begin
            for (int i = 0; i < 5; i++)
                if (done[i]) begin
                    nd[i]++;
                    if (lat[i] == 0) lat[i] = c;
                    got[i] = res[i];
                    gn[i]  = fn[i];
                    gz[i]  = fz[i];
                end
            if (c < 40) tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("latency[%0d] %h*%h", i, x, y), lat[i], lat_exp[i]);
            chk($sformatf("ndone[%0d]", i), nd[i], 1);
            chk($sformatf("result[%0d] %h*%h", i, x, y), got[i], e);
            chk($sformatf("flag_n[%0d]", i), {31'd0, gn[i]}, {31'd0, e[31]});
            chk($sformatf("flag_z[%0d]", i), {31'd0, gz[i]}, {31'd0, e == 32'd0});
            chk($sformatf("hold[%0d]", i), res[i], e);
        end
    endtask

    initial begin
        int          nd;
        logic [31:0] x, y;
        idle(3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("reset busy[%0d]", i), {31'd0, busy[i]}, 32'd0);
            chk($sformatf("reset done[%0d]", i), {31'd0, done[i]}, 32'd0);
            chk($sformatf("reset result[%0d]", i), res[i], 32'd0);
            chk($sformatf("reset flags[%0d]", i), {30'd0, fn[i], fz[i]}, 32'd0);
        end
        reset = 1'b1;
        tick();
        run_op(32'd3, 32'd5, 32'd15);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_op(32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        run_op(32'h1234_5678, 32'h0000_0100, 32'h3456_7800);
        // Starts while busy are ignored; a start in the done cycle is accepted
        op_a  = 32'd7;
        op_b  = 32'd9;
        start = 1'b1;
        tick();
        op_a = 32'd1;
        op_b = 32'd1;
        nd   = 0;
        for (int c = 1; c <= 31; c++) begin
            if (done[1]) nd++;
            tick();
        end
        chk("b2b early done", nd, 0);
        chk("b2b done 32", {31'd0, done[1]}, 32'd1);
        chk("b2b busy 32", {31'd0, busy[1]}, 32'd0);
        chk("b2b result 63", res[1], 32'd63);
        op_a = 32'd2;
        op_b = 32'd2;
        tick();
        start = 1'b0;
        nd    = 0;
        for (int c = 33; c <= 63; c++) begin
            if (done[1]) nd++;
            tick();
        end
        chk("b2b2 early done", nd, 0);
        chk("b2b2 done 64", {31'd0, done[1]}, 32'd1);
        chk("b2b2 result 4", res[1], 32'd4);
        idle(40);
        // Abort in cycle 10, restart in cycle 11
        op_a  = 32'd6;
        op_b  = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy 11", {31'd0, busy[1]}, 32'd0);
        chk("abort result held", res[1], 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        nd    = 0;
        for (int c = 12; c <= 42; c++) begin
            if (done[1]) nd++;
            tick();
        end
        chk("abort no done", nd, 0);
        chk("restart done 43", {31'd0, done[1]}, 32'd1);
        chk("restart result 42", res[1], 32'd42);
        idle(40);
        // Abort while idle drops the simultaneous start in every configuration
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        nd    = 0;
        for (int c = 1; c <= 40; c++) begin
            nd += (done != 5'd0) ? 1 : 0;
            tick();
        end
        chk("idle abort no done", nd, 0);
        chk("idle abort busy", {27'd0, busy}, 32'd0);
        // Asynchronous reset in cycle 5
        op_a  = 32'd3;
        op_b  = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(4);
        reset = 1'b0;
        #1;
        chk("rst busy", {27'd0, busy}, 32'd0);
        chk("rst done", {27'd0, done}, 32'd0);
        chk("rst result", res[1], 32'd0);
        chk("rst flags", {22'd0, fn, fz}, 32'd0);
        tick();
        reset = 1'b1;
        nd    = 0;
        for (int c = 1; c <= 40; c++) begin
            nd += (done != 5'd0) ? 1 : 0;
            tick();
        end
        chk("rst no done", nd, 0);
        for (int k = 0; k < 12; k++) begin
            x = $urandom;
            y = $urandom;
            run_op(x, y, x * y);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
